sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO, the successor to the team's basic synchronous FIFO. It is generalised in depth (any value ≥ 2, not only powers of two) and width. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a read-data valid strobe and defined full/empty simultaneous-access behaviour. It sits between any producer/consumer pair in the same clock domain.

## Interface
- `WIDTH`, 16, data word width in bits (≥ 1)
- `DEPTH`, 16, number of storage entries (≥ 2)
- `AF_LEVEL`, DEPTH-2, fifo_almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 2, fifo_almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- `clk` in 1: single clock; all state changes on rising edge
- `rst_` in 1: reset, asynchronous assert, active-low
- `fifo_data_in` in WIDTH: write data
- `fifo_write` in 1: write request
- `fifo_read` in 1: read request
- `fifo_data_out` out WIDTH: registered read data
- `fifo_rd_valid` out 1: fifo_data_out carries a newly popped word this cycle
- `fifo_full` out 1: count == DEPTH
- `fifo_empty` out 1: count == 0
- `fifo_almost_full` out 1: count ≥ AF_LEVEL
- `fifo_almost_empty` out 1: count ≤ AE_LEVEL
- `fifo_count` out CW = $clog2(DEPTH+1): current occupancy
- `fifo_overflow` out 1: sticky; present only with SYNC_FIFO_ERR_EN
- `fifo_underflow` out 1: sticky; present only with SYNC_FIFO_ERR_EN

## Operation
- State consists of:
  - storage array mem[0..DEPTH-1]
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits
  - cnt, CW bits
- Write is accepted when fifo_write && (!fifo_full || read accepted in the same cycle). On accept, mem[wr_ptr] ← fifo_data_in and wr_ptr advances.
- Read is accepted when fifo_read && !fifo_empty. On accept, fifo_data_out ← mem[rd_ptr], rd_ptr advances and fifo_rd_valid = 1 next cycle; otherwise fifo_rd_valid = 0 and fifo_data_out holds its value.
- Pointer wrap: DEPTH-1 → 0 explicitly. No reliance on binary rollover, so non-power-of-two DEPTH works.
- Count update:
  - cnt +1 on write-only accept
  - cnt −1 on read-only accept
  - cnt unchanged when both accepted or neither accepted
- Simultaneous cases:
  - Full + read + write: both accepted; cnt stays DEPTH.
  - Empty + read + write: write accepted, read rejected; cnt → 1, fifo_rd_valid = 0.
- Rejected requests (write when full without read, read when empty) change no state except the error flags.
- All flags are combinational decodes of registered cnt only, never of current-cycle requests.

## Timing
- Reset (rst_ low, asynchronous) sets:
  - wr_ptr, rd_ptr, cnt = 0
  - fifo_data_out = 0, fifo_rd_valid = 0
  - fifo_empty = 1, fifo_full = 0
  - fifo_almost_empty = 1, fifo_almost_full = (AF_LEVEL == 0 ? 1 : 0), i.e. 0 for legal values
  - error flags = 0
- mem is not reset.
- Reset asserted mid-operation discards all stored data. The first edge after deassertion behaves as from empty.
- Write-to-read latency:
  - A word written at edge N is visible (fifo_empty = 0) after edge N.
  - It can be popped at edge N+1 and appears on fifo_data_out with fifo_rd_valid after edge N+1.
- Read latency is 1 cycle from the accepting edge to data on fifo_data_out.
- Flags and fifo_count change only after a rising edge, never combinationally from inputs.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - fifo_overflow sets on a cycle with fifo_write && fifo_full && no accepted read.
  - fifo_underflow sets on fifo_read && fifo_empty.
  - Both are sticky and cleared only by rst_.
- Not defined: both ports and their logic are absent; rejected requests are silently dropped.

## Test plan
- Reset then DEPTH=16 writes of 0x0000..0x000F, then 16 reads → out 0x0000..0x000F in order, each with fifo_rd_valid. fifo_full high after write 16; fifo_empty high after read 16.
- Fill to 16, then 17th write of 0xDEAD → rejected, count stays 16, 0xDEAD never read back, fifo_overflow = 1 (macro on).
- Full, then read+write 0xBEEF same cycle → count stays 16, out = oldest word. 0xBEEF is read 16th after the remaining 15 words.
- Empty, then read+write 0x1234 same cycle → fifo_rd_valid = 0, count = 1, next read returns 0x1234. Read on empty sets fifo_underflow (macro on).
- DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: 12 interleaved writes/reads crossing pointer wrap → order preserved. almost_full at count 4, almost_empty at count ≤1.
- Fill 10 entries, pulse rst_ low between edges → outputs reset immediately. After release, fifo_empty = 1 and fifo_count = 0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: any DEPTH >= 2, occupancy count, almost-full/empty thresholds, read-valid strobe.
// Define SYNC_FIFO_ERR_EN to add sticky fifo_overflow / fifo_underflow flags.
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] fifo_data_in,
  input  logic             fifo_write,
  input  logic             fifo_read,
  output logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_valid,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             fifo_almost_full,
  output logic             fifo_almost_empty,
  output logic [CW-1:0]    fifo_count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             fifo_overflow,
  output logic             fifo_underflow
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             rd_acc_s;
  logic             wr_acc_s;
  logic             full_s;
  logic             empty_s;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_s            = (cnt_r == CW'(DEPTH));
  assign empty_s           = (cnt_r == {CW{1'b0}});
  assign fifo_full         = full_s;
  assign fifo_empty        = empty_s;
  assign fifo_almost_full  = (cnt_r >= CW'(AF_LEVEL));
  assign fifo_almost_empty = (cnt_r <= CW'(AE_LEVEL));
  assign fifo_count        = cnt_r;

  // Accept decisions; a write into a full FIFO rides on a same-cycle pop.
  always_comb begin
    rd_acc_s = fifo_read && !empty_s;
    wr_acc_s = fifo_write && (!full_s || rd_acc_s);
  end

  // Occupancy next-state.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_r] <= fifo_data_in;
    end
  end

  // Pointers, count and registered read port.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      cnt_r         <= {CW{1'b0}};
      fifo_data_out <= {WIDTH{1'b0}};
      fifo_rd_valid <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r      <= ptr_inc(rd_ptr_r);
        fifo_data_out <= mem[rd_ptr_r];
        fifo_rd_valid <= 1'b1;
      end else begin
        rd_ptr_r      <= rd_ptr_r;
        fifo_data_out <= fifo_data_out;
        fifo_rd_valid <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (fifo_write && full_s && !rd_acc_s) begin
        fifo_overflow <= 1'b1;
      end else begin
        fifo_overflow <= fifo_overflow;
      end
      if (fifo_read && empty_s) begin
        fifo_underflow <= 1'b1;
      end else begin
        fifo_underflow <= fifo_underflow;
      end
    end
  end
`endif

endmodule
